// File: rtl/stopwatch_pkg.sv
// Shared types and default widths for the stopwatch controller and timer.
package stopwatch_pkg;

    localparam int SW_DATA_WIDTH = 16;
    localparam int SW_LAP_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge press detector for one synchronized button level.
// The previous-level register has no reset, so a button held through reset yields no press.
module btn_edge (
    input  logic clk,
    input  logic level,
    output logic press
);

    logic level_q;

    always_ff @(posedge clk) begin
        level_q <= level;
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button-level stopwatch controller: start/stop/reset strobes, display path and lap freeze.
// Optional lap feature enabled by defining STOPWATCH_LAP_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | timer stopped and cleared, waiting for start
// ST_RUN   | timer counting, display live
// ST_PAUSE | timer stopped, holding its count
// ST_LAP   | timer counting, display frozen at lap value
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DATA_WIDTH = SW_DATA_WIDTH,
    parameter int LAP_WIDTH  = SW_LAP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_ss,
    input  logic                  btn_lr,
    input  logic [DATA_WIDTH-1:0] count_in,
    output logic                  sw_start,
    output logic                  sw_stop,
    output logic                  sw_reset,
    output logic [DATA_WIDTH-1:0] display,
    output logic                  running,
    output logic                  lap_active,
    output logic [LAP_WIDTH-1:0]  lap_count
);

    sw_state_t state_q, state_d;
    logic      ss_press, lr_press;
    logic      start_d, stop_d, reset_d;
    logic      freeze;

    btn_edge u_edge_ss (.clk(clk), .level(btn_ss), .press(ss_press));
    btn_edge u_edge_lr (.clk(clk), .level(btn_lr), .press(lr_press));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ss has priority; a simultaneous lr press is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ss_press) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ss_press) state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                else if (lr_press) state_d = ST_LAP;
`endif
            end
            ST_PAUSE: begin
                if (ss_press)      state_d = ST_RUN;
                else if (lr_press) state_d = ST_IDLE;
            end
            ST_LAP: begin
                if (ss_press)      state_d = ST_PAUSE;
                else if (lr_press) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_d    = ss_press && (state_q == ST_IDLE || state_q == ST_PAUSE);
        stop_d     = ss_press && (state_q == ST_RUN  || state_q == ST_LAP);
        reset_d    = !ss_press && lr_press && (state_q == ST_IDLE || state_q == ST_PAUSE);
        running    = (state_q == ST_RUN) || (state_q == ST_LAP);
`ifdef STOPWATCH_LAP_EN
        lap_active = (state_q == ST_LAP);
        freeze     = (state_q == ST_LAP) && (state_d == ST_LAP);
`else
        lap_active = 1'b0;
        freeze     = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_start <= 1'b0;
            sw_stop  <= 1'b0;
            sw_reset <= 1'b0;
            display  <= '0;
        end else begin
            sw_start <= start_d;
            sw_stop  <= stop_d;
            sw_reset <= reset_d;
            if (!freeze) display <= count_in;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [LAP_WIDTH-1:0] lap_q;
    logic                 lap_inc;

    assign lap_inc = (state_q == ST_RUN) && (state_d == ST_LAP);

    always_ff @(posedge clk) begin
        if (reset || reset_d) begin
            lap_q <= '0;
        end else if (lap_inc && lap_q != '1) begin
            lap_q <= lap_q + LAP_WIDTH'(1);
        end
    end

    assign lap_count = lap_q;
`else
    assign lap_count = '0;
`endif

endmodule
